// File: rtl/code_loader_pkg.sv
// code_loader_pkg
//   Shared constants and types for the byte-stream program loader.
//   LDR_SYNC       : frame start byte
//   LDR_MAX_WORDS  : largest word count a frame may carry
//   ldr_state_e    : 3-bit loader FSM state encoding (LDR_S_*)
//   count_legal()  : decides whether a received word-count field is acceptable
package code_loader_pkg;

  localparam logic [7:0] LDR_SYNC      = 8'hA5;
  localparam logic [9:0] LDR_MAX_WORDS = 10'd512;

  typedef enum logic [2:0] {
    LDR_S_IDLE    = 3'd0,
    LDR_S_CNT_HI  = 3'd1,
    LDR_S_CNT_LO  = 3'd2,
    LDR_S_DATA_HI = 3'd3,
    LDR_S_DATA_LO = 3'd4,
    LDR_S_CHK     = 3'd5,
    LDR_S_DONE    = 3'd6,
    LDR_S_ERR     = 3'd7
  } ldr_state_e;

  // The count is 10 bits wide so that 512 (8'h02, 8'h00) is expressible;
  // the two low bits of the high byte extend the low byte and everything
  // above them must be zero.
  function automatic logic count_legal(input logic [7:0] hi, input logic [7:0] lo);
    logic [9:0] n;
    n = {hi[1:0], lo};
    return (hi[7:2] == 6'd0) && (n != 10'd0) && (n <= LDR_MAX_WORDS);
  endfunction

endpackage

// File: rtl/ldr_timer.sv
// ldr_timer
//   Inter-byte watchdog for the program loader. Counts clock cycles while
//   enabled and flags when TIMEOUT cycles have gone by without a clear.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   clr_i : restart the count (a byte arrived)
//   en_i  : count while high; the count is held at zero while low
//   tc_o  : terminal count, high in the TIMEOUT-th idle cycle
module ldr_timer #(
  parameter int TIMEOUT = 50000,
  parameter int TW      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // The count saturates at LAST so a stalled enable cannot wrap it back
  // to a harmless value.
  always_comb begin
    count_d = count_q;
    if (clr_i || !en_i) begin
      count_d = '0;
    end else if (count_q != LAST) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Deliberately independent of clr_i: a byte landing in the expiring
  // cycle must not rescue the frame.
  assign tc_o = en_i && (count_q == LAST);

endmodule

// File: rtl/code_loader.sv
// code_loader
//   Receives framed bytes from a UART and writes 16-bit instruction words
//   into code memory, holding the processor in reset until a frame with a
//   valid checksum has been loaded.
//   Frame: A5, CNT_HI, CNT_LO, {W_HI, W_LO} x N, CHK (XOR of bytes between
//   SYNC and CHK).
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   rx_data   : received byte, valid with rx_valid
//   rx_valid  : one-cycle strobe per byte
//   code_w_en : code-memory write strobe, one cycle per word
//   code_addr : code-memory word address
//   code_data : code-memory write data {hi, lo}
//   run       : processor run enable
//   cpu_rst   : processor reset, high while loading
//   busy      : frame in progress
//   err       : sticky frame error
module code_loader
  import code_loader_pkg::*;
#(
  parameter int TIMEOUT = 50000,
  parameter int TW      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        code_w_en,
  output logic [8:0]  code_addr,
  output logic [15:0] code_data,
  output logic        run,
  output logic        cpu_rst,
  output logic        busy,
  output logic        err
);

  ldr_state_e  state_q;
  logic [7:0]  chk_q;
  logic [7:0]  cnt_hi_q;
  logic [7:0]  hi_q;
  logic [9:0]  n_q;
  logic [8:0]  idx_q;
  logic        code_w_en_q;
  logic [8:0]  code_addr_q;
  logic [15:0] code_data_q;
  logic        run_q;
  logic        cpu_rst_q;
  logic        busy_q;
  logic        err_q;
  logic        timeout;

  ldr_timer #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (rx_valid),
    .en_i  (busy_q),
    .tc_o  (timeout)
  );

  // Single FSM block; every output is a register updated alongside the
  // state so the processor-facing controls never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LDR_S_IDLE;
      chk_q       <= 8'h00;
      cnt_hi_q    <= 8'h00;
      hi_q        <= 8'h00;
      n_q         <= 10'd0;
      idx_q       <= 9'd0;
      code_w_en_q <= 1'b0;
      code_addr_q <= 9'd0;
      code_data_q <= 16'h0000;
      run_q       <= 1'b0;
      cpu_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      code_w_en_q <= 1'b0;
      if (timeout) begin
        state_q   <= LDR_S_ERR;
        err_q     <= 1'b1;
        run_q     <= 1'b0;
        cpu_rst_q <= 1'b1;
        busy_q    <= 1'b0;
      end else if (rx_valid) begin
        case (state_q)
          // SYNC is only recognised outside a frame; inside a frame A5 is data.
          LDR_S_IDLE, LDR_S_DONE, LDR_S_ERR: begin
            if (rx_data == LDR_SYNC) begin
              state_q   <= LDR_S_CNT_HI;
              cpu_rst_q <= 1'b1;
              run_q     <= 1'b0;
              err_q     <= 1'b0;
              chk_q     <= 8'h00;
              busy_q    <= 1'b1;
            end
          end
          LDR_S_CNT_HI: begin
            cnt_hi_q <= rx_data;
            chk_q    <= chk_q ^ rx_data;
            state_q  <= LDR_S_CNT_LO;
          end
          LDR_S_CNT_LO: begin
            chk_q <= chk_q ^ rx_data;
            if (count_legal(cnt_hi_q, rx_data)) begin
              n_q     <= {cnt_hi_q[1:0], rx_data};
              idx_q   <= 9'd0;
              state_q <= LDR_S_DATA_HI;
            end else begin
              state_q   <= LDR_S_ERR;
              err_q     <= 1'b1;
              run_q     <= 1'b0;
              cpu_rst_q <= 1'b1;
              busy_q    <= 1'b0;
            end
          end
          LDR_S_DATA_HI: begin
            hi_q    <= rx_data;
            chk_q   <= chk_q ^ rx_data;
            state_q <= LDR_S_DATA_LO;
          end
          // idx stops at N-1 so a 512-word frame never wraps back to 0.
          LDR_S_DATA_LO: begin
            code_w_en_q <= 1'b1;
            code_addr_q <= idx_q;
            code_data_q <= {hi_q, rx_data};
            chk_q       <= chk_q ^ rx_data;
            if ({1'b0, idx_q} == n_q - 10'd1) begin
              state_q <= LDR_S_CHK;
            end else begin
              idx_q   <= idx_q + 9'd1;
              state_q <= LDR_S_DATA_HI;
            end
          end
          LDR_S_CHK: begin
            busy_q <= 1'b0;
            if (rx_data == chk_q) begin
              state_q   <= LDR_S_DONE;
              run_q     <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q   <= LDR_S_ERR;
              err_q     <= 1'b1;
              run_q     <= 1'b0;
              cpu_rst_q <= 1'b1;
            end
          end
          default: begin
            state_q <= LDR_S_IDLE;
          end
        endcase
      end
    end
  end

  assign code_w_en = code_w_en_q;
  assign code_addr = code_addr_q;
  assign code_data = code_data_q;
  assign run       = run_q;
  assign cpu_rst   = cpu_rst_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_code_loader.sv
// tb_code_loader
//   Self-checking bench for code_loader. Expected memory writes go into a
//   scoreboard queue as bytes are driven and are popped by a monitor when
//   code_w_en pulses. Short frames run from a step table; timeout, the
//   512-word frame and the async reset are hand-written sequences.
module tb_code_loader;

  localparam int TIMEOUT = 8;

  typedef struct {
    logic [8:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  data;
    logic        expBusy;
    logic        expRun;
    logic        expCpuRst;
    logic        expErr;
    logic        wr;
    logic [8:0]  wrAddr;
    logic [15:0] wrData;
  } step_t;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        code_w_en;
  logic [8:0]  code_addr;
  logic [15:0] code_data;
  logic        run;
  logic        cpu_rst;
  logic        busy;
  logic        err;

  int    compared;
  int    mismatched;
  wr_t   sb[$];
  step_t steps[$];

  code_loader #(
    .TIMEOUT (TIMEOUT),
    .TW      (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .code_w_en (code_w_en),
    .code_addr (code_addr),
    .code_data (code_data),
    .run       (run),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drives one byte for exactly one cycle; returns 1ns after the edge that consumed it.
  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic expectWrite(input logic [8:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    sb.push_back(w);
  endtask

  task automatic checkState(input string tag, input logic b, input logic r, input logic c, input logic e);
    checkOutput({tag, " busy"},    {15'd0, busy},    {15'd0, b});
    checkOutput({tag, " run"},     {15'd0, run},     {15'd0, r});
    checkOutput({tag, " cpu_rst"}, {15'd0, cpu_rst}, {15'd0, c});
    checkOutput({tag, " err"},     {15'd0, err},     {15'd0, e});
  endtask

  task automatic checkDrained(input string tag);
    @(posedge clk);
    #1;
    checkOutput({tag, " pending writes"}, 16'(sb.size()), 16'd0);
  endtask

  function automatic void addStep(input logic [7:0] d, input logic b, input logic r,
                                  input logic c, input logic e, input logic w,
                                  input logic [8:0] a, input logic [15:0] wd);
    step_t s;
    s.data      = d;
    s.expBusy   = b;
    s.expRun    = r;
    s.expCpuRst = c;
    s.expErr    = e;
    s.wr        = w;
    s.wrAddr    = a;
    s.wrData    = wd;
    steps.push_back(s);
  endfunction

  // Every write the DUT makes must match the oldest expected write.
  always @(negedge clk) begin
    if (rst === 1'b0 && code_w_en === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected write: addr %h data %h, expected no write", code_addr, code_data);
      end else begin
        wr_t exp;
        exp = sb.pop_front();
        checkOutput("write addr", {7'd0, code_addr}, {7'd0, exp.addr});
        checkOutput("write data", code_data, exp.data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  chk;
    logic [15:0] w;

    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;

    // Checksum of 00 02 12 34 AB CD is 8'h42; 41 is a deliberate bad checksum.
    addStep(8'h33, 0, 0, 1, 0, 0, 9'd0, 16'h0000);
    addStep(8'hA5, 1, 0, 1, 0, 0, 9'd0, 16'h0000);
    addStep(8'h00, 1, 0, 1, 0, 0, 9'd0, 16'h0000);
    addStep(8'h02, 1, 0, 1, 0, 0, 9'd0, 16'h0000);
    addStep(8'h12, 1, 0, 1, 0, 0, 9'd0, 16'h0000);
    addStep(8'h34, 1, 0, 1, 0, 1, 9'd0, 16'h1234);
    addStep(8'hAB, 1, 0, 1, 0, 0, 9'd0, 16'h0000);
    addStep(8'hCD, 1, 0, 1, 0, 1, 9'd1, 16'hABCD);
    addStep(8'h42, 0, 1, 0, 0, 0, 9'd0, 16'h0000);
    addStep(8'hA5, 1, 0, 1, 0, 0, 9'd0, 16'h0000);
    addStep(8'h00, 1, 0, 1, 0, 0, 9'd0, 16'h0000);
    addStep(8'h02, 1, 0, 1, 0, 0, 9'd0, 16'h0000);
    addStep(8'h12, 1, 0, 1, 0, 0, 9'd0, 16'h0000);
    addStep(8'h34, 1, 0, 1, 0, 1, 9'd0, 16'h1234);
    addStep(8'hAB, 1, 0, 1, 0, 0, 9'd0, 16'h0000);
    addStep(8'hCD, 1, 0, 1, 0, 1, 9'd1, 16'hABCD);
    addStep(8'h41, 0, 0, 1, 1, 0, 9'd0, 16'h0000);
    addStep(8'hA5, 1, 0, 1, 0, 0, 9'd0, 16'h0000);
    addStep(8'h00, 1, 0, 1, 0, 0, 9'd0, 16'h0000);
    addStep(8'h00, 0, 0, 1, 1, 0, 9'd0, 16'h0000);
    addStep(8'hA5, 1, 0, 1, 0, 0, 9'd0, 16'h0000);
    addStep(8'h02, 1, 0, 1, 0, 0, 9'd0, 16'h0000);
    addStep(8'h01, 0, 0, 1, 1, 0, 9'd0, 16'h0000);
    addStep(8'hA5, 1, 0, 1, 0, 0, 9'd0, 16'h0000);
    addStep(8'h04, 1, 0, 1, 0, 0, 9'd0, 16'h0000);
    addStep(8'h01, 0, 0, 1, 1, 0, 9'd0, 16'h0000);
    // A5 bytes inside a frame are data: checksum 00^01^A5^A5 = 01.
    addStep(8'hA5, 1, 0, 1, 0, 0, 9'd0, 16'h0000);
    addStep(8'h00, 1, 0, 1, 0, 0, 9'd0, 16'h0000);
    addStep(8'h01, 1, 0, 1, 0, 0, 9'd0, 16'h0000);
    addStep(8'hA5, 1, 0, 1, 0, 0, 9'd0, 16'h0000);
    addStep(8'hA5, 1, 0, 1, 0, 1, 9'd0, 16'hA5A5);
    addStep(8'h01, 0, 1, 0, 0, 0, 9'd0, 16'h0000);

    #12;
    checkState("reset", 0, 0, 1, 0);
    checkOutput("reset code_w_en", {15'd0, code_w_en}, 16'd0);
    checkOutput("reset code_addr", {7'd0, code_addr}, 16'd0);
    checkOutput("reset code_data", code_data, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] step table");
    for (int i = 0; i < steps.size(); i++) begin
      if (steps[i].wr) expectWrite(steps[i].wrAddr, steps[i].wrData);
      applyStimulus(steps[i].data);
      checkState($sformatf("step%0d", i), steps[i].expBusy, steps[i].expRun,
                 steps[i].expCpuRst, steps[i].expErr);
    end
    checkDrained("table");

    $display("[TB] inter-byte timeout");
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h12);
    repeat (7) @(posedge clk);
    #1;
    checkState("timeout-7", 1, 0, 1, 0);
    @(posedge clk);
    #1;
    checkState("timeout-8", 0, 0, 1, 1);
    // 01^12^34 = 27.
    expectWrite(9'd0, 16'h1234);
    applyStimulus(8'hA5);
    checkState("recover sync", 1, 0, 1, 0);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    applyStimulus(8'h27);
    checkState("recover done", 0, 1, 0, 0);
    checkDrained("timeout");

    $display("[TB] timeout coinciding with a byte");
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h12);
    repeat (6) @(posedge clk);
    applyStimulus(8'h34);
    checkState("tmo vs byte", 0, 0, 1, 1);
    checkDrained("tmo vs byte");

    $display("[TB] 512-word frame");
    chk = 8'h02 ^ 8'h00;
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    for (int i = 0; i < 512; i++) begin
      w   = 16'(i);
      chk = chk ^ w[15:8] ^ w[7:0];
      expectWrite(w[8:0], w);
      applyStimulus(w[15:8]);
      applyStimulus(w[7:0]);
    end
    applyStimulus(chk);
    checkState("512 done", 0, 1, 0, 0);
    checkOutput("512 last addr", {7'd0, code_addr}, 16'd511);
    checkOutput("512 last data", code_data, 16'h01FF);
    checkDrained("512");

    $display("[TB] restart from DONE and async reset");
    applyStimulus(8'hA5);
    checkState("restart", 1, 0, 1, 0);
    expectWrite(9'd0, 16'h1122);
    expectWrite(9'd1, 16'h3344);
    applyStimulus(8'h00);
    applyStimulus(8'h03);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h55);
    checkOutput("pre-rst addr", {7'd0, code_addr}, 16'd1);
    #2;
    rst = 1'b1;
    #1;
    checkState("async rst", 0, 0, 1, 0);
    checkOutput("async rst code_addr", {7'd0, code_addr}, 16'd0);
    checkOutput("async rst code_data", code_data, 16'h0000);
    checkOutput("async rst code_w_en", {15'd0, code_w_en}, 16'd0);
    checkOutput("async rst pending writes", 16'(sb.size()), 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkState("after rst", 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
